// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// The control bundle travels with each beat through every stage.
package pipe_adder_pkg;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   typedef struct packed {
      logic valid;
      logic sub;
      logic carry;
      logic a_msb;
      logic b_msb;
   } stage_ctl_t;

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-wide slice of the pipelined adder: adds its chunk with the incoming
// carry and registers result chunk, carry-out and the beat's control bundle.
module adder_stage
   import pipe_adder_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  stage_ctl_t       ctl_i,
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   output stage_ctl_t       ctl_o,
   output logic [CHUNK-1:0] sum_o
);

   logic [CHUNK-1:0] b_eff_s;
   logic [CHUNK:0]   add_s;
   stage_ctl_t       ctl_d;
   stage_ctl_t       ctl_q;
   logic [CHUNK-1:0] sum_d;
   logic [CHUNK-1:0] sum_q;

   // Subtraction inverts this chunk of b; the borrow sense is already folded into carry.
   always_comb begin
      ctl_d   = ctl_q;
      sum_d   = sum_q;
      b_eff_s = ctl_i.sub ? ~b_i : b_i;
      add_s   = {1'b0, a_i} + {1'b0, b_eff_s} + {{CHUNK{1'b0}}, ctl_i.carry};
      if (en_i) begin
         ctl_d       = ctl_i;
         ctl_d.carry = add_s[CHUNK];
         sum_d       = add_s[CHUNK-1:0];
      end else begin
         ctl_d = ctl_q;
         sum_d = sum_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctl_q <= '0;
         sum_q <= '0;
      end else begin
         ctl_q <= ctl_d;
         sum_q <= sum_d;
      end
   end

   assign ctl_o = ctl_q;
   assign sum_o = sum_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK per stage, with valid/ready
// handshake on both sides and a whole-pipeline stall on backpressure.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   if ((WIDTH < 2) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $fatal(1, "pipe_adder: illegal WIDTH/STAGES combination");
   end

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   logic       advance_s;
   stage_ctl_t in_ctl_s;
   stage_ctl_t out_ctl_s;

   // Subtract is a + ~b + ~cin, so stage 0 starts from cin ^ sub.
   always_comb begin
      in_ctl_s       = '0;
      in_ctl_s.valid = in_valid;
      in_ctl_s.sub   = sub;
      in_ctl_s.carry = cin ^ sub;
      in_ctl_s.a_msb = a[WIDTH-1];
      in_ctl_s.b_msb = b[WIDTH-1];
   end

   assign advance_s = !out_ctl_s.valid || out_ready;
   assign in_ready  = advance_s;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int SRC_W = WIDTH - k * CHUNK;

      stage_ctl_t             ctl_in_s;
      stage_ctl_t             ctl_out_s;
      logic [SRC_W-1:0]       a_src_s;
      logic [SRC_W-1:0]       b_src_s;
      logic [CHUNK-1:0]       sum_chunk_s;
      logic [(k+1)*CHUNK-1:0] asm_s;

      if (k == 0) begin : g_head
         assign ctl_in_s = in_ctl_s;
         assign a_src_s  = a;
         assign b_src_s  = b;
         assign asm_s    = sum_chunk_s;
      end else begin : g_body
         localparam int PREV_W = SRC_W + CHUNK;

         logic [SRC_W-1:0]   a_rem_q;
         logic [SRC_W-1:0]   b_rem_q;
         logic [k*CHUNK-1:0] low_q;

         // Unadded operand chunks and finished sum chunks move in step with the beat.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_rem_q <= '0;
               b_rem_q <= '0;
               low_q   <= '0;
            end else if (advance_s) begin
               a_rem_q <= g_stage[k-1].a_src_s[PREV_W-1:CHUNK];
               b_rem_q <= g_stage[k-1].b_src_s[PREV_W-1:CHUNK];
               low_q   <= g_stage[k-1].asm_s;
            end else begin
               a_rem_q <= a_rem_q;
               b_rem_q <= b_rem_q;
               low_q   <= low_q;
            end
         end

         assign ctl_in_s = g_stage[k-1].ctl_out_s;
         assign a_src_s  = a_rem_q;
         assign b_src_s  = b_rem_q;
         assign asm_s    = {sum_chunk_s, low_q};
      end

      adder_stage #(
         .CHUNK(CHUNK)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .en_i  (advance_s),
         .ctl_i (ctl_in_s),
         .a_i   (a_src_s[CHUNK-1:0]),
         .b_i   (b_src_s[CHUNK-1:0]),
         .ctl_o (ctl_out_s),
         .sum_o (sum_chunk_s)
      );
   end

   assign out_ctl_s = g_stage[STAGES-1].ctl_out_s;
   assign out_valid = out_ctl_s.valid;
   assign sum       = g_stage[STAGES-1].asm_s;
   assign cout      = out_ctl_s.carry;
   // Signed overflow: both addends share a sign that the result does not.
   assign ovf       = (out_ctl_s.a_msb == (out_ctl_s.b_msb ^ out_ctl_s.sub)) &&
                      (sum[WIDTH-1] != out_ctl_s.a_msb);

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised self-checking bench for pipe_adder against an integer-arithmetic
// reference model, plus a WIDTH=8/STAGES=1 instance for the degenerate build.
module tb_pipe_adder;

   localparam int W = 16;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, sum;
   logic         in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
   logic [7:0]   a8, b8, sum8;

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   bit           lat_chk = 1'b0;
   bit           stalled_q = 1'b0;
   bit           last_in_xfer = 1'b0;
   bit           last_out_xfer = 1'b0;
   logic [W+1:0] held_q = '0;
   logic [W+1:0] exp_q[$];
   int           acc_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // {ovf, cout, sum} from plain unsigned/signed integer arithmetic
   function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rc, input logic rs);
      longint ua, ub, uc, res, sa, sb, sres, smax, smin;
      logic   co, ov;
      ua   = longint'(ra);
      ub   = longint'(rb);
      uc   = longint'(rc);
      sa   = longint'($signed(ra));
      sb   = longint'($signed(rb));
      smax = (longint'(1) <<< (W - 1)) - longint'(1);
      smin = -(longint'(1) <<< (W - 1));
      if (!rs) begin
         res  = ua + ub + uc;
         co   = res[W];
         sres = sa + sb + uc;
      end else begin
         res  = ua - ub - uc;
         co   = (ua >= (ub + uc));
         sres = sa - sb - uc;
      end
      ov = (sres > smax) || (sres < smin);
      return {ov, co, res[W-1:0]};
   endfunction

   task automatic step(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input bit icin, input bit isub, input bit ordy);
      logic [W+1:0] e;
      int           t;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = icin;
      sub       = isub;
      out_ready = ordy;
      #1;
      if (stalled_q) begin
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_data", 32'({ovf, cout, sum}), 32'(held_q));
      end
      stalled_q = out_valid && !out_ready;
      held_q    = {ovf, cout, sum};
      if (stalled_q) check_eq("in_ready_stall", 32'(in_ready), 32'd0);
      last_out_xfer = out_valid && out_ready;
      if (last_out_xfer) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            check_eq("sb_sum", 32'(sum), 32'(e[W-1:0]));
            check_eq("sb_cout", 32'(cout), 32'(e[W]));
            check_eq("sb_ovf", 32'(ovf), 32'(e[W+1]));
            if (lat_chk) check_eq("latency", 32'(cyc - t), 32'(S));
         end
      end
      last_in_xfer = in_valid && in_ready;
      if (last_in_xfer) begin
         exp_q.push_back(ref_model(ia, ib, icin, isub));
         acc_q.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic run_directed(input logic [W-1:0] da, input logic [W-1:0] db, input bit dc,
                               input bit ds, input logic [W-1:0] es, input bit ec, input bit eo);
      int waited;
      step(1'b1, da, db, dc, ds, 1'b1);
      waited = 0;
      do begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         waited++;
      end while (!out_valid && waited < 12);
      check_eq("dir_wait", 32'(waited), 32'(S));
      check_eq("dir_valid", 32'(out_valid), 32'd1);
      check_eq("dir_sum", 32'(sum), 32'(es));
      check_eq("dir_cout", 32'(cout), 32'(ec));
      check_eq("dir_ovf", 32'(ovf), 32'(eo));
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, recv;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sum", 32'(sum), 32'd0);
      check_eq("rst_cout", 32'(cout), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid8", 32'(out_valid8), 32'd0);

      lat_chk = 1'b1;
      run_directed(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
      run_directed(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // full rate: 8 mixed beats back to back
      for (int i = 0; i < 8; i++)
         step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      drain();

      // backpressure: 6 beats with a 5-cycle out_ready=0 window mid-stream
      lat_chk = 1'b0;
      sent = 0;
      recv = 0;
      for (int i = 0; i < 60 && (sent < 6 || exp_q.size() > 0); i++) begin
         step(sent < 6, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), !(i >= 4 && i < 9));
         if (last_in_xfer) sent++;
         if (last_out_xfer) recv++;
      end
      check_eq("bp_sent", 32'(sent), 32'd6);
      check_eq("bp_recv", 32'(recv), 32'd6);

      // random valid/ready traffic
      for (int i = 0; i < 300; i++)
         step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0));
      drain();

      // reset with three beats in flight
      for (int i = 0; i < 3; i++)
         step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      stalled_q = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         check_eq("post_rst_valid", 32'(out_valid), 32'd0);
      end

      // degenerate WIDTH=8, STAGES=1 build
      @(negedge clk);
      in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
      #1;
      check_eq("w8_in_ready", 32'(in_ready8), 32'd1);
      check_eq("w8_pre_valid", 32'(out_valid8), 32'd0);
      @(negedge clk);
      in_valid8 = 1'b0;
      #1;
      check_eq("w8_valid", 32'(out_valid8), 32'd1);
      check_eq("w8_sum", 32'(sum8), 32'h00);
      check_eq("w8_cout", 32'(cout8), 32'd1);
      check_eq("w8_ovf", 32'(ovf8), 32'd0);
      @(negedge clk);
      #1;
      check_eq("w8_after", 32'(out_valid8), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
